// File: rtl/button_press_classifier.sv
// -----------------------------------------------------------------------------
// button_press_classifier
//
// Sorts debounced button gestures into short, double and long presses. While a
// long press is held it also emits auto-repeat pulses. All outputs are
// registered. The switch input must already be synchronous to i_Clk.
//
// Parameters:
//   LONG_COUNT   consecutive high samples that make a long press
//   DOUBLE_GAP   maximum low samples between a first release and a second press
//   REPEAT_COUNT clocks between o_Repeat pulses during a long hold
//   CNT_W        counter width; must hold the largest of the three counts
//
// Ports:
//   i_Clk     system clock
//   i_Rst_L   asynchronous active-low reset
//   i_Switch  debounced button level, 1 = pressed
//   i_Enable  0 holds the classifier idle and suppresses every event
//   o_Short   one-cycle pulse: single short press confirmed
//   o_Double  one-cycle pulse: double press confirmed
//   o_Long    one-cycle pulse: long-press threshold reached
//   o_Repeat  one-cycle pulse every REPEAT_COUNT clocks during a long hold
//   o_Held    level, high while a long press is being held
//   o_Busy    level, high whenever a gesture is in progress
// -----------------------------------------------------------------------------
module button_press_classifier #(
  parameter int LONG_COUNT   = 25000000,
  parameter int DOUBLE_GAP   = 6250000,
  parameter int REPEAT_COUNT = 2500000,
  parameter int CNT_W        = 25
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  input  logic i_Enable,
  output logic o_Short,
  output logic o_Double,
  output logic o_Long,
  output logic o_Repeat,
  output logic o_Held,
  output logic o_Busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    GAP       = 3'd2,
    PRESS2    = 3'd3,
    LONG_HOLD = 3'd4
  } state_t;

  // Terminal counts: every timed state exits on reaching these, so the
  // counter never wraps.
  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_COUNT - 1);
  localparam logic [CNT_W-1:0] GAP_TC    = CNT_W'(DOUBLE_GAP - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             prev_reg;
  logic             seen_low_reg;
  logic             short_reg;
  logic             double_reg;
  logic             long_reg;
  logic             repeat_reg;
  logic             held_reg;
  logic             busy_reg;

  // A button that is already high when reset releases must be seen low once
  // before its rising level counts as a press; seen_low_reg gates that.
  logic press_edge;
  assign press_edge = i_Switch & ~prev_reg & seen_low_reg;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      prev_reg     <= 1'b0;
      seen_low_reg <= 1'b0;
      short_reg    <= 1'b0;
      double_reg   <= 1'b0;
      long_reg     <= 1'b0;
      repeat_reg   <= 1'b0;
      held_reg     <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      // Level tracking continues while disabled, so a press already in
      // progress when enable returns produces no edge until it is released.
      prev_reg <= i_Switch;
      if (!i_Switch) begin
        seen_low_reg <= 1'b1;
      end

      // Event outputs are pulses; default low every cycle.
      short_reg  <= 1'b0;
      double_reg <= 1'b0;
      long_reg   <= 1'b0;
      repeat_reg <= 1'b0;

      if (!i_Enable) begin
        state_reg <= IDLE;
        cnt_reg   <= '0;
        held_reg  <= 1'b0;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (press_edge) begin
              state_reg <= PRESS1;
              cnt_reg   <= '0;
              busy_reg  <= 1'b1;
            end
          end

          PRESS1: begin
            if (!i_Switch) begin
              state_reg <= GAP;
              cnt_reg   <= '0;
            end else if (cnt_reg == LONG_TC) begin
              state_reg <= LONG_HOLD;
              cnt_reg   <= '0;
              long_reg  <= 1'b1;
              held_reg  <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end

          GAP: begin
            // The press is tested first so it wins over a same-cycle timeout.
            if (press_edge) begin
              state_reg <= PRESS2;
              cnt_reg   <= '0;
            end else if (cnt_reg == GAP_TC) begin
              state_reg <= IDLE;
              cnt_reg   <= '0;
              short_reg <= 1'b1;
              busy_reg  <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end

          PRESS2: begin
            if (!i_Switch) begin
              state_reg  <= IDLE;
              cnt_reg    <= '0;
              double_reg <= 1'b1;
              busy_reg   <= 1'b0;
            end else if (cnt_reg != CNT_MAX) begin
              // No long detection here; the count only saturates.
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end

          LONG_HOLD: begin
            // Release is tested first so it suppresses a same-cycle repeat.
            if (!i_Switch) begin
              state_reg <= IDLE;
              cnt_reg   <= '0;
              held_reg  <= 1'b0;
              busy_reg  <= 1'b0;
            end else if (cnt_reg == REPEAT_TC) begin
              cnt_reg    <= '0;
              repeat_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end

          default: begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            held_reg  <= 1'b0;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_Short  = short_reg;
  assign o_Double = double_reg;
  assign o_Long   = long_reg;
  assign o_Repeat = repeat_reg;
  assign o_Held   = held_reg;
  assign o_Busy   = busy_reg;

endmodule

// File: tb/tb_button_press_classifier.sv
// -----------------------------------------------------------------------------
// tb_button_press_classifier
//
// Directed gestures drive the classifier with short thresholds. A timestamp
// based gesture model predicts every output each cycle; literal timing
// expectations for each scenario pin the model itself.
// -----------------------------------------------------------------------------
module tb_button_press_classifier;

  localparam int LC = 20;
  localparam int DG = 8;
  localparam int RC = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw = 1'b1;
  logic en = 1'b1;
  logic o_short, o_double, o_long, o_repeat, o_held, o_busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Observed event log (filled by the compare process).
  int n_short = 0, n_double = 0, n_long = 0, n_repeat = 0;
  int short_cyc = -1, double_cyc = -1, long_cyc = -1;
  int rep_q[$];

  // Gesture model: phases plus timestamps of the moments that matter.
  typedef enum {G_IDLE, G_DOWN1, G_GAP, G_DOWN2, G_LONG} phase_t;
  phase_t m_phase = G_IDLE;
  logic m_prev = 1'b0, m_armed = 1'b0;
  int t_press = 0, t_release = 0, t_long = 0;
  logic e_short, e_double, e_long, e_repeat, e_held, e_busy;

  button_press_classifier #(
    .LONG_COUNT(LC), .DOUBLE_GAP(DG), .REPEAT_COUNT(RC), .CNT_W(5)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch(sw), .i_Enable(en),
    .o_Short(o_short), .o_Double(o_double), .o_Long(o_long),
    .o_Repeat(o_repeat), .o_Held(o_held), .o_Busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic got, input logic want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0b, want %0b", name, cyc, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic model_reset();
    m_phase = G_IDLE; m_prev = 1'b0; m_armed = 1'b0;
    {e_short, e_double, e_long, e_repeat, e_held, e_busy} = '0;
  endtask

  // One sampled edge: cyc is the index of that edge.
  task automatic model_step(input logic s, input logic e);
    logic pressed;
    pressed = s && !m_prev && m_armed;
    m_prev = s;
    if (!s) m_armed = 1'b1;
    {e_short, e_double, e_long, e_repeat} = '0;
    if (!e) begin
      m_phase = G_IDLE;
    end else begin
      case (m_phase)
        G_IDLE:  if (pressed) begin m_phase = G_DOWN1; t_press = cyc; end
        G_DOWN1: if (!s) begin m_phase = G_GAP; t_release = cyc; end
                 else if (cyc - t_press == LC) begin
                   m_phase = G_LONG; t_long = cyc; e_long = 1'b1;
                 end
        G_GAP:   if (pressed) m_phase = G_DOWN2;
                 else if (cyc - t_release == DG) begin m_phase = G_IDLE; e_short = 1'b1; end
        G_DOWN2: if (!s) begin m_phase = G_IDLE; e_double = 1'b1; end
        G_LONG:  if (!s) m_phase = G_IDLE;
                 else if ((cyc - t_long) % RC == 0) e_repeat = 1'b1;
        default: m_phase = G_IDLE;
      endcase
    end
    e_held = (m_phase == G_LONG);
    e_busy = (m_phase != G_IDLE);
  endtask

  // Compare process: every cycle, 2 ns after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (!rst_n) model_reset();
      else model_step(sw, en);
      check("short", o_short, e_short);
      check("double", o_double, e_double);
      check("long", o_long, e_long);
      check("repeat", o_repeat, e_repeat);
      check("held", o_held, e_held);
      check("busy", o_busy, e_busy);
      tests++;
      if (int'(o_short) + int'(o_double) + int'(o_long) + int'(o_repeat) > 1) begin
        fails++;
        $display("FAIL exclusive at cycle %0d: got %0b%0b%0b%0b, want at most one",
                 cyc, o_short, o_double, o_long, o_repeat);
      end
      if (o_short)  begin n_short++;  short_cyc = cyc;  end
      if (o_double) begin n_double++; double_cyc = cyc; end
      if (o_long)   begin n_long++;   long_cyc = cyc;   end
      if (o_repeat) begin n_repeat++; rep_q.push_back(cyc); end
    end
  end

  // Called just after a falling edge: hold the inputs for n sampling edges.
  task automatic apply(input logic s, input logic e, input int n);
    sw = s; en = e;
    repeat (n) @(negedge clk);
  endtask

  int p, r, r2, b_s, b_d, b_l, b_r;

  task automatic snap();
    b_s = n_short; b_d = n_double; b_l = n_long; b_r = n_repeat;
  endtask

  initial begin
    // 1: reset with the button held, then released from reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    snap();
    apply(1, 1, 6);
    check("t1 busy while stuck high", o_busy, 1'b0);
    apply(0, 1, 2);
    check("t1 busy after low", o_busy, 1'b0);
    apply(1, 1, 3);
    check("t1 busy after new press", o_busy, 1'b1);
    apply(0, 1, 12);
    check_int("t1 short count", n_short - b_s, 1);
    $display("[TB] t1 stuck-high reset: shorts=%0d", n_short - b_s);

    // 2: single short press
    snap();
    apply(1, 1, 5);
    r = cyc + 1;
    apply(0, 1, 14);
    check_int("t2 short count", n_short - b_s, 1);
    check_int("t2 short delay", short_cyc - r, 8);
    check_int("t2 other events", (n_double - b_d) + (n_long - b_l) + (n_repeat - b_r), 0);
    $display("[TB] t2 short press: short at release+%0d", short_cyc - r);

    // 3: double press
    snap();
    apply(1, 1, 5);
    apply(0, 1, 3);
    apply(1, 1, 4);
    r2 = cyc + 1;
    apply(0, 1, 14);
    check_int("t3 double count", n_double - b_d, 1);
    check_int("t3 double edge", double_cyc, r2);
    check_int("t3 short count", n_short - b_s, 0);
    $display("[TB] t3 double press: double at cycle %0d", double_cyc);

    // 4: long press with auto-repeat
    snap();
    p = cyc + 1;
    apply(1, 1, 32);
    check_int("t4 long delay", long_cyc - p, 20);
    check_int("t4 repeat count", n_repeat - b_r, 2);
    check_int("t4 first repeat", rep_q[rep_q.size() - 2] - long_cyc, 5);
    check_int("t4 second repeat", rep_q[rep_q.size() - 1] - long_cyc, 10);
    check("t4 held while down", o_held, 1'b1);
    apply(0, 1, 1);
    check("t4 held after release", o_held, 1'b0);
    check("t4 busy after release", o_busy, 1'b0);
    apply(0, 1, 12);
    $display("[TB] t4 long press: long at press+%0d, repeats=%0d", long_cyc - p, n_repeat - b_r);

    // 5: second press exactly on the gap timeout count
    snap();
    apply(1, 1, 5);
    apply(0, 1, 8);
    apply(1, 1, 3);
    check("t5 busy in second press", o_busy, 1'b1);
    r2 = cyc + 1;
    apply(0, 1, 14);
    check_int("t5 short count", n_short - b_s, 0);
    check_int("t5 double count", n_double - b_d, 1);
    check_int("t5 double edge", double_cyc, r2);
    $display("[TB] t5 press on gap limit: doubles=%0d shorts=%0d", n_double - b_d, n_short - b_s);

    // 6: disable during a long hold
    snap();
    apply(1, 1, 25);
    check_int("t6 long count", n_long - b_l, 1);
    apply(1, 0, 1);
    check("t6 held after disable", o_held, 1'b0);
    apply(1, 1, 30);
    check_int("t6 repeats", n_repeat - b_r, 0);
    check_int("t6 no new long", n_long - b_l, 1);
    check("t6 busy while ignored", o_busy, 1'b0);
    apply(0, 1, 3);
    apply(1, 1, 5);
    apply(0, 1, 12);
    check_int("t6 short after re-press", n_short - b_s, 1);
    $display("[TB] t6 disable mid-hold: repeats=%0d shorts=%0d", n_repeat - b_r, n_short - b_s);

    // 7: reset in the middle of a gesture discards it
    snap();
    apply(1, 1, 6);
    rst_n = 1'b0;
    apply(0, 1, 2);
    rst_n = 1'b1;
    apply(0, 1, 25);
    check_int("t7 events after reset", (n_short - b_s) + (n_long - b_l) + (n_double - b_d), 0);
    $display("[TB] t7 reset mid-gesture: events=%0d", (n_short - b_s) + (n_long - b_l));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
